// File: rtl/mult_4x4_rr_sched.sv
// rtl/mult_4x4_rr_sched.sv - round-robin scheduler sharing one external 4x4 multiplier
module mult_4x4_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [4*NUM_REQ-1:0]  req_a,
    input  logic [4*NUM_REQ-1:0]  req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [3:0]            mul_a,
    output logic [3:0]            mul_b,
    input  logic [7:0]            mul_product,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ID_W-1:0]       resp_id,
    output logic [7:0]            resp_product,
    output logic [15:0]           op_count
);

    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t          r_state;
    logic [ID_W-1:0] r_rr_ptr;
    logic [3:0]      r_op_a;
    logic [3:0]      r_op_b;
    logic [ID_W-1:0] r_op_id;
    logic            r_resp_valid;
    logic [ID_W-1:0] r_resp_id;
    logic [7:0]      r_resp_product;
    logic [15:0]     r_op_count;

    logic            w_found;
    logic [ID_W-1:0] w_gidx;
    logic [ID_W:0]   w_sum;
    logic [ID_W-1:0] w_next_ptr;
    logic [3:0]      w_sel_a;
    logic [3:0]      w_sel_b;
    logic            w_grant;

    // Rotating priority search: first valid requester at or after rr_ptr, modulo NUM_REQ.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_sum   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
            if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                w_sum = w_sum - (ID_W+1)'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && (w_sum == (ID_W+1)'(j)) && req_valid[j]) begin
                    w_found = 1'b1;
                    w_gidx  = ID_W'(j);
                end
            end
        end
    end

    assign w_grant    = (r_state == IDLE) && w_found;
    assign w_next_ptr = (w_gidx == ID_W'(NUM_REQ-1)) ? '0 : w_gidx + 1'b1;

    always_comb begin
        req_ready = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gidx == ID_W'(i)) begin
                req_ready[i] = w_grant;
                w_sel_a      = req_a[4*i +: 4];
                w_sel_b      = req_b[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_rr_ptr       <= '0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_op_id        <= '0;
            r_resp_valid   <= 1'b0;
            r_resp_id      <= '0;
            r_resp_product <= '0;
            r_op_count     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= w_sel_b;
                        r_op_id  <= w_gidx;
                        r_rr_ptr <= w_next_ptr;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_resp_product <= mul_product;
                    r_resp_id      <= r_op_id;
                    r_resp_valid   <= 1'b1;
                    r_state        <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        r_resp_valid <= 1'b0;
                        if (r_op_count != 16'hFFFF) begin
                            r_op_count <= r_op_count + 16'd1;
                        end
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operands stay parked on the multiplier between operations.
    assign mul_a        = r_op_a;
    assign mul_b        = r_op_b;
    assign resp_valid   = r_resp_valid;
    assign resp_id      = r_resp_id;
    assign resp_product = r_resp_product;
    assign op_count     = r_op_count;

endmodule

// File: tb/tb_mult_4x4_rr_sched.sv
// tb/tb_mult_4x4_rr_sched.sv - scoreboard bench for mult_4x4_rr_sched
module tb_mult_4x4_rr_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [4*NUM_REQ-1:0] req_a = '0;
    logic [4*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [3:0]           mul_a;
    logic [3:0]           mul_b;
    logic [7:0]           mul_product;
    logic                 resp_valid;
    logic                 resp_ready = 1'b1;
    logic [ID_W-1:0]      resp_id;
    logic [7:0]           resp_product;
    logic [15:0]          op_count;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ng     = 0;
    int gid  [16];
    int gcyc [16];
    logic [NUM_REQ-1:0] g_last;
    logic [ID_W+7:0] sb [$];

    always #5 clk = ~clk;

    // Stand-in for the shared multiplier instance.
    assign mul_product = {4'b0, mul_a} * {4'b0, mul_b};

    mult_4x4_rr_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_product(resp_product), .op_count(op_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL resp_unexpected: got id=%0d prod=%0d expected no response", resp_id, resp_product);
            end else begin
                chk("resp_id_prod", {22'b0, resp_id, resp_product}, {22'b0, sb.pop_front()});
            end
        end
    end

    task automatic push_exp(input int id, input int prod);
        sb.push_back({ID_W'(id), 8'(prod)});
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[4*i +: 4] = 4'(a);
        req_b[4*i +: 4] = 4'(b);
        req_valid[i]    = 1'b1;
    endtask

    // Sample the grant at negedge, then drop the granted request just after the edge.
    task automatic step();
        @(negedge clk);
        g_last = req_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (g_last[i] && ng < 16) begin
                gid[ng]  = i;
                gcyc[ng] = cyc;
                ng++;
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~g_last;
        cyc++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(sb.size() == 0 && req_valid == '0 && !resp_valid) && n < 60) begin
            step();
            n++;
        end
        if (n >= 60) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ng = 0;
    endtask

    initial begin
        int exp_ord [4];
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_op_count", 32'(op_count), 0);
        chk("rst_mul_ab", {24'b0, mul_a, mul_b}, 0);
        chk("rst_resp_id_prod", {22'b0, resp_id, resp_product}, 0);
        rst = 1'b0;

        // Single request, max operands
        set_req(1, 15, 15);
        push_exp(1, 225);
        #1;
        chk("t1_req_ready", 32'(req_ready), 32'h2);
        step();
        chk("t1_calc_ready", 32'(req_ready), 0);
        chk("t1_calc_valid", 32'(resp_valid), 0);
        chk("t1_mul_ab", {24'b0, mul_a, mul_b}, 32'hFF);
        step();
        chk("t1_resp_valid", 32'(resp_valid), 1);
        chk("t1_resp_prod", 32'(resp_product), 225);
        step();
        chk("t1_op_count", 32'(op_count), 1);
        chk("t1_done_valid", 32'(resp_valid), 0);

        // All four held, fair order from pointer 0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_req(i, i + 1, 3);
            push_exp(i, 3 * (i + 1));
        end
        drain();
        chk("t2_grant_count", ng, 4);
        for (int k = 0; k < 4 && k < ng; k++) chk("t2_grant_order", gid[k], k);
        for (int k = 0; k < 3 && k + 1 < ng; k++) chk("t2_grant_spacing", gcyc[k+1] - gcyc[k], 3);
        chk("t2_op_count", 32'(op_count), 4);

        // Backpressure with another request waiting
        ng = 0;
        resp_ready = 1'b0;
        set_req(2, 7, 5);
        push_exp(2, 35);
        push_exp(0, 8);
        step();
        set_req(0, 2, 4);
        step();
        for (int k = 0; k < 5; k++) begin
            chk("t3_hold_valid", 32'(resp_valid), 1);
            chk("t3_hold_id_prod", {22'b0, resp_id, resp_product}, {22'b0, 2'd2, 8'd35});
            chk("t3_hold_ready", 32'(req_ready), 0);
            step();
        end
        resp_ready = 1'b1;
        drain();
        chk("t3_grant_count", ng, 2);
        if (ng >= 2) begin
            chk("t3_grant0", gid[0], 2);
            chk("t3_grant1", gid[1], 0);
        end

        // Pointer wrap: 3, then 0 ahead of 3
        ng = 0;
        set_req(3, 9, 9);
        push_exp(3, 81);
        push_exp(0, 13);
        push_exp(3, 30);
        step();
        set_req(0, 1, 13);
        set_req(3, 15, 2);
        drain();
        exp_ord = '{3, 0, 3, 0};
        chk("t4_grant_count", ng, 3);
        for (int k = 0; k < 3 && k < ng; k++) chk("t4_grant_order", gid[k], exp_ord[k]);

        // Reset during CALC drops the operation
        set_req(1, 5, 5);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(resp_valid), 0);
        chk("t5_rst_count", 32'(op_count), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t5_no_resp", 32'(resp_valid), 0);
        end
        set_req(2, 0, 9);
        push_exp(2, 0);
        drain();
        chk("t5_op_count", 32'(op_count), 1);

        // Saturation of the completion counter
        force dut.r_op_count = 16'hFFFE;
        #1;
        release dut.r_op_count;
        #1;
        chk("t6_preload", 32'(op_count), 32'hFFFE);
        set_req(1, 3, 4);
        push_exp(1, 12);
        drain();
        chk("t6_count_max", 32'(op_count), 32'hFFFF);
        set_req(3, 1, 1);
        push_exp(3, 1);
        drain();
        chk("t6_count_sat", 32'(op_count), 32'hFFFF);
        chk("t6_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
